// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared FSM states and fixed-point CORDIC constants
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // atan(2^-i) in Q3.24; entries past i=24 round to zero
    localparam logic [63:0] ATAN_TAB_24 [32] = '{
        64'hC90FDB, 64'h76B19C, 64'h3EB6EC, 64'h1FD5BB,
        64'h0FFAAE, 64'h07FF55, 64'h03FFEB, 64'h01FFFD,
        64'h010000, 64'h008000, 64'h004000, 64'h002000,
        64'h001000, 64'h000800, 64'h000400, 64'h000200,
        64'h000100, 64'h000080, 64'h000040, 64'h000020,
        64'h000010, 64'h000008, 64'h000004, 64'h000002,
        64'h000001, 64'h000000, 64'h000000, 64'h000000,
        64'h000000, 64'h000000, 64'h000000, 64'h000000
    };
    localparam logic [63:0] K_24       = 64'h9B74EE;
    localparam logic [63:0] PI_24      = 64'h3243F6B;
    localparam logic [63:0] HALF_PI_24 = 64'h1921FB5;

    localparam real K_REAL  = 0.6072529350088813;
    localparam real PI_REAL = 3.141592653589793;

    function automatic real atan_pow2(input int i);
        real x;
        real term;
        real sum;
        if (i == 0) return PI_REAL / 4.0;
        x    = 1.0 / (2.0 ** i);
        term = x;
        sum  = 0.0;
        for (int k = 0; k < 30; k++) begin
            sum  = sum + (((k % 2) != 0) ? -term : term) / real'(2 * k + 1);
            term = term * x * x;
        end
        return sum;
    endfunction

    function automatic logic [63:0] to_fixed(input real v, input int w);
        return 64'(longint'(v * (2.0 ** w)));
    endfunction

    function automatic logic [63:0] atan_const(input int i, input int w);
        if (w == 24) return ATAN_TAB_24[i[4:0]];
        return to_fixed(atan_pow2(i), w);
    endfunction

    function automatic logic [63:0] gain_const(input int w);
        if (w == 24) return K_24;
        return to_fixed(K_REAL, w);
    endfunction

    function automatic logic [63:0] pi_const(input int w);
        if (w == 24) return PI_24;
        return to_fixed(PI_REAL, w);
    endfunction

    function automatic logic [63:0] half_pi_const(input int w);
        if (w == 24) return HALF_PI_24;
        return to_fixed(PI_REAL / 2.0, w);
    endfunction

endpackage

// File: rtl/cordic_microrot.sv
// rtl/cordic_microrot.sv - one combinational CORDIC rotation-mode step
module cordic_microrot #(
    parameter int W = 27
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] z,
    input  logic        [4:0]   i,
    input  logic signed [W-1:0] atan,
    output logic signed [W-1:0] x_nx,
    output logic signed [W-1:0] y_nx,
    output logic signed [W-1:0] z_nx
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;

    assign xs = x >>> i;
    assign ys = y >>> i;

    always_comb begin
        if (!z[W-1]) begin
            x_nx = x - ys;
            y_nx = y + xs;
            z_nx = z - atan;
        end else begin
            x_nx = x + ys;
            y_nx = y - xs;
            z_nx = z + atan;
        end
    end

endmodule

// File: rtl/cosine_sine_seq.sv
// rtl/cosine_sine_seq.sv - iterative CORDIC cosine/sine with valid/ready handshakes
module cosine_sine_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int ITERS = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH+2:0]   angle,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH+1:0]   cos_out,
    output logic signed [WIDTH+1:0]   sin_out
);

    localparam int AW = WIDTH + 3;
    localparam int OW = WIDTH + 2;

    localparam logic signed [AW-1:0] K_VAL        = AW'(gain_const(WIDTH));
    localparam logic signed [AW-1:0] PI_VAL       = AW'(pi_const(WIDTH));
    localparam logic signed [AW-1:0] HALF_PI      = AW'(half_pi_const(WIDTH));
    localparam logic signed [AW-1:0] NEG_HALF_PI  = -HALF_PI;
    localparam logic        [4:0]    LAST_ITER    = 5'(ITERS - 1);

    state_t               state;
    state_t               state_nx;
    logic                 live;
    logic [4:0]           iter;
    logic                 neg;
    logic signed [AW-1:0] x;
    logic signed [AW-1:0] y;
    logic signed [AW-1:0] z;
    logic signed [AW-1:0] x_nx;
    logic signed [AW-1:0] y_nx;
    logic signed [AW-1:0] z_nx;
    logic signed [AW-1:0] z_fold;
    logic                 neg_fold;
    logic                 accept;
    logic signed [AW-1:0] atan_tab [32];

    for (genvar g = 0; g < 32; g++) begin : g_atan
        assign atan_tab[g] = AW'(atan_const(g, WIDTH));
    end

    cordic_microrot #(.W(AW)) u_rot (
        .x    (x),
        .y    (y),
        .z    (z),
        .i    (iter),
        .atan (atan_tab[iter]),
        .x_nx (x_nx),
        .y_nx (y_nx),
        .z_nx (z_nx)
    );

    // Fold |angle| > pi/2 into the convergence range; the pi shift is undone by negating results
    always_comb begin
        z_fold   = angle;
        neg_fold = 1'b0;
        if (angle > HALF_PI) begin
            z_fold   = angle - PI_VAL;
            neg_fold = 1'b1;
        end else if (angle < NEG_HALF_PI) begin
            z_fold   = angle + PI_VAL;
            neg_fold = 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = live;
                if (in_valid && live) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (iter == LAST_ITER) state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nx = in_valid ? ST_RUN : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // live holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            live    <= 1'b0;
            iter    <= '0;
            neg     <= 1'b0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (accept) begin
                x    <= K_VAL;
                y    <= '0;
                z    <= z_fold;
                neg  <= neg_fold;
                iter <= '0;
            end else if (state == ST_RUN) begin
                x    <= x_nx;
                y    <= y_nx;
                z    <= z_nx;
                iter <= iter + 5'd1;
                if (iter == LAST_ITER) begin
                    cos_out <= OW'(neg ? -x_nx : x_nx);
                    sin_out <= OW'(neg ? -y_nx : y_nx);
                end
            end
        end
    end

endmodule

// File: tb/tb_cosine_sine_seq.sv
// tb/tb_cosine_sine_seq.sv - scoreboard bench for cosine_sine_seq
module tb_cosine_sine_seq;

    localparam int     WIDTH = 24;
    localparam int     ITERS = 24;
    localparam longint TOL   = 24;
    localparam real    ONE_R = 16777216.0;
    localparam longint PI_I  = 64'h3243F6B;
    localparam longint HP_I  = 64'h1921FB5;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH+2:0] angle     = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [WIDTH+1:0] cos_out;
    logic signed [WIDTH+1:0] sin_out;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint sb_cos [$];
    longint sb_sin [$];
    longint sb_acc [$];
    bit     accepted   = 1'b0;
    bit     lat_seen   = 1'b0;
    bit     rand_ready = 1'b0;

    always #5 clk = ~clk;

    cosine_sine_seq #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle     (angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        diff = obs - exp;
        checks++;
        if (diff > tol || diff < -tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        real a;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (in_valid && in_ready) begin
            a = real'(angle) / ONE_R;
            sb_cos.push_back(longint'($cos(a) * ONE_R));
            sb_sin.push_back(longint'($sin(a) * ONE_R));
            sb_acc.push_back(cyc + 1);
            accepted = 1'b1;
        end
        if (out_valid) begin
            if (sb_cos.size() == 0) begin
                check_val("spurious_out_valid", 1, 0, 0);
            end else begin
                if (!lat_seen) begin
                    check_val("latency", cyc - sb_acc[0] + 1, ITERS + 1, 0);
                    lat_seen = 1'b1;
                end
                if (out_ready) begin
                    check_val("cos", cos_out, sb_cos[0], TOL);
                    check_val("sin", sin_out, sb_sin[0], TOL);
                    void'(sb_cos.pop_front());
                    void'(sb_sin.pop_front());
                    void'(sb_acc.pop_front());
                    lat_seen = 1'b0;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input longint a, output longint acc_edge);
        in_valid = 1'b1;
        angle    = 27'(a);
        accepted = 1'b0;
        for (int n = 0; n < 200 && !accepted; n++) tick();
        if (!accepted) check_val("accept_timeout", 0, 1, 0);
        acc_edge = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && sb_cos.size() != 0; n++) tick();
        if (sb_cos.size() != 0) check_val("drain_timeout", sb_cos.size(), 0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint dirs [9];
        longint acc1;
        longint acc2;
        longint c0;

        dirs = '{0, HP_I, -HP_I, PI_I, -PI_I, HP_I + 1, -HP_I - 1,
                 longint'(-PI_R3() * ONE_R), PI_I / 4};

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 0, 0);
        check_val("rst_out_valid", out_valid, 0, 0);
        check_val("rst_cos", cos_out, 0, 0);
        check_val("rst_sin", sin_out, 0, 0);
        rst_n = 1'b1;
        #1;
        check_val("in_ready_before_edge", in_ready, 0, 0);
        tick();
        check_val("in_ready_after_edge", in_ready, 1, 0);

        check_val("out_valid_idle", out_valid, 0, 0);
        send(0, acc1);
        drain();
        check_val("zero_cos_const", cos_out, 64'h1000000, TOL);
        check_val("zero_sin_const", sin_out, 0, TOL);

        foreach (dirs[k]) begin
            send(dirs[k], acc1);
            drain();
        end

        send(HP_I / 3, acc1);
        send(-HP_I / 5, acc2);
        check_val("throughput", acc2 - acc1, ITERS + 1, 0);
        drain();

        send(HP_I / 2, acc1);
        out_ready = 1'b0;
        for (int n = 0; n < 100 && !out_valid; n++) tick();
        check_val("stall_reach_done", out_valid, 1, 0);
        in_valid = 1'b1;
        angle    = 27'(-HP_I / 2);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("stall_in_ready", in_ready, 0, 0);
            check_val("stall_out_valid", out_valid, 1, 0);
            check_val("stall_cos", cos_out, sb_cos[0], TOL);
        end
        out_ready = 1'b1;
        c0 = cyc;
        send(-HP_I / 2, acc2);
        check_val("same_edge_accept", acc2, c0 + 1, 0);
        drain();

        send(PI_I * 3 / 4, acc1);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 0, 0);
        check_val("midrst_in_ready", in_ready, 0, 0);
        check_val("midrst_cos", cos_out, 0, 0);
        check_val("midrst_sin", sin_out, 0, 0);
        check_val("midrst_iter", dut.iter, 0, 0);
        check_val("midrst_neg", dut.neg, 0, 0);
        sb_cos.delete();
        sb_sin.delete();
        sb_acc.delete();
        lat_seen = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("midrst_ready_low", in_ready, 0, 0);
        tick();
        check_val("midrst_ready_high", in_ready, 1, 0);
        check_val("midrst_idle_valid", out_valid, 0, 0);
        send(-PI_I * 3 / 4, acc1);
        drain();

        rand_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(longint'($urandom_range(0, 2 * PI_I)) - PI_I, acc1);
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic real PI_R3();
        return 3.141592653589793 / 3.0;
    endfunction

endmodule
